rpn_calculator_gen2: RTL
========================

RPN_CALCULATOR_GEN2 -- requirements
Module: rpn_calculator_gen2

Interface
REQ-001 Parameter DATA_WIDTH, default 8, operand/stack word width (>=4).
REQ-002 Parameter STACK_DEPTH, default 16, stack entries (power of two, >=4).
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 cmd_valid  in  1  command offered.
REQ-006 cmd_ready  out  1  block can accept a command this cycle.
REQ-007 cmd_push  in  1  1 = push cmd_data; 0 = execute cmd_op.
REQ-008 cmd_op  in  3  operation code, valid with cmd_push=0.
REQ-009 cmd_data  in  DATA_WIDTH  value to push.
REQ-010 err_clear  in  1  clears sticky error flags.
REQ-011 top_out  out  DATA_WIDTH  current top of stack; 0 when empty.
REQ-012 result_valid  out  1  one-cycle pulse: operation result written to stack.
REQ-013 depth  out  clog2(STACK_DEPTH)+1  number of occupied entries.
REQ-014 empty / full  out  1 each  depth==0 / depth==STACK_DEPTH.
REQ-015 carry  out  1  arithmetic flag of last completed operation.
REQ-016 err_underflow / err_overflow  out  1 each  sticky error flags.

Function
REQ-017 Handshake: command accepted on rising edge where cmd_valid && cmd_ready; cmd_valid while cmd_ready=0 SHALL be ignored and has no effect.
REQ-018 FSM states IDLE, POP_B, POP_A, EXEC, WRITE; cmd_ready=1 only in IDLE.
REQ-019 Push accepted in IDLE: written at accept edge, depth+1, FSM stays IDLE; back-to-back pushes every cycle supported.
REQ-020 Push when full: no write, depth unchanged, err_overflow set, FSM stays IDLE.
REQ-021 Operate accepted with depth>=2: IDLE->POP_B (edge 0); POP_B pops top into B (edge 1); POP_A pops next into A (edge 2); EXEC computes R and carry (edge 3); WRITE pushes R, returns IDLE (edge 4); result_valid=1 during the cycle after edge 4.
REQ-022 Operate accepted with depth<2: stack unchanged, err_underflow set, FSM stays IDLE, no result_valid.
REQ-023 Opcodes (A = second, B = top): 000 A+B; 001 A-B; 010 A&B; 011 A|B; 100 A^B; 101 low DATA_WIDTH bits of A*B; 110 A<<B; 111 A>>B logical; shift by B>=DATA_WIDTH yields 0.
REQ-024 carry: ADD = carry-out; SUB = borrow (A<B unsigned); MUL = 1 if any upper product bit nonzero; logic/shift ops clear it; updated only at EXEC edge.
REQ-025 Net effect of an operation: depth-1, top_out=R.
REQ-026 top_out combinational from stack top and pointer; reflects intermediate pops during POP_B/POP_A.
REQ-027 Sticky errors: set by their condition, cleared by err_clear; set and clear in same cycle -> set wins.
REQ-028 All arithmetic unsigned, modulo 2^DATA_WIDTH.

Reset
REQ-029 rst_n low asynchronously forces: FSM IDLE, depth 0, empty 1, full 0, top_out 0, result_valid 0, carry 0, both errors 0, cmd_ready 1 once rst_n high.
REQ-030 Reset mid-operation discards the operation; popped operands are lost; stack contents need not be cleared, only the pointer.
REQ-031 First command accepted on the first rising edge after rst_n deasserts.

Verification
REQ-032 W=8: push 7, push 5, op 001 -> result_valid 5 cycles after accept edge, top_out 2, depth 1, carry 0.
REQ-033 Push 3, push 5, op 001 -> top_out 0xFE, carry 1; push 0x10, op 101 on 0x20,0x10 -> top_out 0x00, carry 1.
REQ-034 Fill 16 pushes -> full 1; 17th push -> err_overflow 1, depth 16; err_clear -> err_overflow 0.
REQ-035 Single push then op 000 -> err_underflow 1, depth 1, top_out unchanged, no result_valid.
REQ-036 cmd_valid held during POP_A -> not accepted, cmd_ready 0; rst_n low during EXEC -> depth 0, top_out 0, no result_valid.
REQ-037 Push 0x81, push 9, op 110 -> top_out 0; op 111 on 0x80,3 -> 0x10; rerun REQ-032 with DATA_WIDTH=16, STACK_DEPTH=64.

Source files
------------

// File: rtl/rpn_calculator_gen2.sv
// ============================================================================
// Module   : rpn_calculator_gen2
// Brief    : Stack-based RPN calculator with push/operate command interface.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rpn_calculator_gen2 #(
    parameter int DATA_WIDTH  = 8,
    parameter int STACK_DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic                           cmd_push,
    input  logic [2:0]                     cmd_op,
    input  logic [DATA_WIDTH-1:0]          cmd_data,
    input  logic                           err_clear,
    output logic [DATA_WIDTH-1:0]          top_out,
    output logic                           result_valid,
    output logic [$clog2(STACK_DEPTH):0]   depth,
    output logic                           empty,
    output logic                           full,
    output logic                           carry,
    output logic                           err_underflow,
    output logic                           err_overflow
);

    localparam int c_IDX_W = $clog2(STACK_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_POP_B = 3'd1,
        S_POP_A = 3'd2,
        S_EXEC  = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [DATA_WIDTH-1:0]   r_stack [STACK_DEPTH];
    logic [c_IDX_W:0]        r_depth;
    logic [DATA_WIDTH-1:0]   r_a;
    logic [DATA_WIDTH-1:0]   r_b;
    logic [DATA_WIDTH-1:0]   r_result;
    logic [2:0]              r_op;
    logic                    r_carry;
    logic                    r_result_valid;
    logic                    r_err_underflow;
    logic                    r_err_overflow;

    logic                    w_accept;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_two;
    logic                    w_push_wr;
    logic                    w_push_ovf;
    logic                    w_op_start;
    logic                    w_op_unf;
    logic [c_IDX_W-1:0]      w_wr_idx;
    logic [c_IDX_W-1:0]      w_top_idx;
    logic [DATA_WIDTH-1:0]   w_top;
    logic [DATA_WIDTH:0]     w_sum;
    logic [DATA_WIDTH:0]     w_diff;
    logic [2*DATA_WIDTH-1:0] w_prod;
    logic                    w_shift_big;
    logic [DATA_WIDTH-1:0]   w_result;
    logic                    w_carry;

    // Power-of-two depth: only the full count sets the pointer MSB
    assign w_full     = r_depth[c_IDX_W];
    assign w_empty    = (r_depth == '0);
    assign w_two      = |r_depth[c_IDX_W:1];
    assign w_wr_idx   = r_depth[c_IDX_W-1:0];
    assign w_top_idx  = w_wr_idx - c_IDX_W'(1);
    assign w_top      = w_empty ? '0 : r_stack[w_top_idx];

    assign w_accept   = cmd_valid && (r_state == S_IDLE);
    assign w_push_wr  = w_accept && cmd_push && !w_full;
    assign w_push_ovf = w_accept && cmd_push && w_full;
    assign w_op_start = w_accept && !cmd_push && w_two;
    assign w_op_unf   = w_accept && !cmd_push && !w_two;

    assign cmd_ready     = (r_state == S_IDLE);
    assign top_out       = w_top;
    assign depth         = r_depth;
    assign empty         = w_empty;
    assign full          = w_full;
    assign carry         = r_carry;
    assign result_valid  = r_result_valid;
    assign err_underflow = r_err_underflow;
    assign err_overflow  = r_err_overflow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_op_start) w_next_state = S_POP_B;
            S_POP_B: w_next_state = S_POP_A;
            S_POP_A: w_next_state = S_EXEC;
            S_EXEC:  w_next_state = S_WRITE;
            S_WRITE: w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_sum       = {1'b0, r_a} + {1'b0, r_b};
        w_diff      = {1'b0, r_a} - {1'b0, r_b};
        w_prod      = {{DATA_WIDTH{1'b0}}, r_a} * {{DATA_WIDTH{1'b0}}, r_b};
        w_shift_big = ({1'b0, r_b} >= (DATA_WIDTH+1)'(DATA_WIDTH));
        w_result    = '0;
        w_carry     = 1'b0;
        case (r_op)
            3'b000: begin w_result = w_sum[DATA_WIDTH-1:0];  w_carry = w_sum[DATA_WIDTH];  end
            3'b001: begin w_result = w_diff[DATA_WIDTH-1:0]; w_carry = w_diff[DATA_WIDTH]; end
            3'b010: w_result = r_a & r_b;
            3'b011: w_result = r_a | r_b;
            3'b100: w_result = r_a ^ r_b;
            3'b101: begin
                w_result = w_prod[DATA_WIDTH-1:0];
                w_carry  = |w_prod[2*DATA_WIDTH-1:DATA_WIDTH];
            end
            3'b110: w_result = w_shift_big ? '0 : (r_a << r_b);
            default: w_result = w_shift_big ? '0 : (r_a >> r_b);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_depth        <= '0;
            r_a            <= '0;
            r_b            <= '0;
            r_op           <= '0;
            r_result       <= '0;
            r_carry        <= 1'b0;
            r_result_valid <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_push_wr)  r_depth <= r_depth + (c_IDX_W+1)'(1);
                    if (w_op_start) r_op    <= cmd_op;
                end
                S_POP_B: begin
                    r_b     <= w_top;
                    r_depth <= r_depth - (c_IDX_W+1)'(1);
                end
                S_POP_A: begin
                    r_a     <= w_top;
                    r_depth <= r_depth - (c_IDX_W+1)'(1);
                end
                S_EXEC: begin
                    r_result <= w_result;
                    r_carry  <= w_carry;
                end
                S_WRITE: begin
                    r_depth        <= r_depth + (c_IDX_W+1)'(1);
                    r_result_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Set has priority over clear so a same-cycle error is never lost
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_underflow <= 1'b0;
            r_err_overflow  <= 1'b0;
        end else begin
            r_err_underflow <= w_op_unf   | (r_err_underflow & ~err_clear);
            r_err_overflow  <= w_push_ovf | (r_err_overflow  & ~err_clear);
        end
    end

    // Storage is not reset; only the pointer defines valid contents
    always_ff @(posedge clk) begin
        if (w_push_wr) begin
            r_stack[w_wr_idx] <= cmd_data;
        end else if (r_state == S_WRITE) begin
            r_stack[w_wr_idx] <= r_result;
        end
    end

endmodule

`default_nettype wire
